// File: rtl/div_iter_unit_if.sv
// rtl/div_iter_unit_if.sv - E-stage handshake and operand bundle for the iterative divider
interface div_iter_unit_if #(
  parameter int DATA_W = 32
);
  logic                start_i;
  logic                signed_i;
  logic                annul_i;
  logic [DATA_W-1:0]   opdata1_i;
  logic [DATA_W-1:0]   opdata2_i;
  logic                busy_o;
  logic                ready_o;
  logic [2*DATA_W-1:0] result_o;

  // Pipeline side drives requests and consumes stall/result.
  modport master (
    output start_i, signed_i, annul_i, opdata1_i, opdata2_i,
    input  busy_o, ready_o, result_o
  );

  // Divider side.
  modport slave (
    input  start_i, signed_i, annul_i, opdata1_i, opdata2_i,
    output busy_o, ready_o, result_o
  );
endinterface

// File: rtl/div_iter_unit.sv
// rtl/div_iter_unit.sv - radix-2 restoring DIV/DIVU divider; optional early out via DIV_EARLY_OUT_EN
module div_iter_unit #(
  parameter int DATA_W = 32
) (
  input logic            clk,
  input logic            rst,
  div_iter_unit_if.slave bus
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;      // partial remainder
  logic [DATA_W-1:0]   quot_q, quot_d;    // dividend bits shift out, quotient bits shift in
  logic [DATA_W-1:0]   dvsr_q, dvsr_d;    // divisor magnitude
  logic                sign1_q, sign1_d;  // dividend negative in signed mode
  logic                sign2_q, sign2_d;  // divisor negative in signed mode
  logic [2*DATA_W-1:0] result_q, result_d;

  logic [DATA_W-1:0]   mag1, mag2;
  logic [DATA_W:0]     partial;
  logic                q_bit;
  logic [DATA_W-1:0]   rem_next, quot_next, q_fix, r_fix;
  logic                busy, ready;

  // Operand magnitudes and one restoring step with the signed fix-up of its outcome.
  always_comb begin
    mag1      = (bus.signed_i && bus.opdata1_i[DATA_W-1]) ? -bus.opdata1_i : bus.opdata1_i;
    mag2      = (bus.signed_i && bus.opdata2_i[DATA_W-1]) ? -bus.opdata2_i : bus.opdata2_i;
    partial   = {rem_q, quot_q[DATA_W-1]};
    q_bit     = (partial >= {1'b0, dvsr_q});
    rem_next  = q_bit ? DATA_W'(partial - {1'b0, dvsr_q}) : partial[DATA_W-1:0];
    quot_next = {quot_q[DATA_W-2:0], q_bit};
    q_fix     = (sign1_q ^ sign2_q) ? -quot_next : quot_next;
    r_fix     = sign1_q ? -rem_next : rem_next;
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    dvsr_d   = dvsr_q;
    sign1_d  = sign1_q;
    sign2_d  = sign2_q;
    result_d = result_q;
    busy     = (state_q == ON) || (state_q == DIVZERO) ||
               ((state_q == IDLE) && bus.start_i && !bus.annul_i);
    ready    = (state_q == END);
    if (bus.annul_i) begin
      // Flush beats everything, including a new request in the same cycle.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            if (bus.opdata2_i == '0) begin
              state_d = DIVZERO;
              quot_d  = bus.opdata1_i;  // raw dividend becomes the remainder half
`ifdef DIV_EARLY_OUT_EN
            end else if (mag1 < mag2) begin
              state_d  = END;
              result_d = {bus.opdata1_i, {DATA_W{1'b0}}};
`endif
            end else begin
              state_d = ON;
              quot_d  = mag1;
              dvsr_d  = mag2;
              rem_d   = '0;
              cnt_d   = '0;
              sign1_d = bus.signed_i & bus.opdata1_i[DATA_W-1];
              sign2_d = bus.signed_i & bus.opdata2_i[DATA_W-1];
            end
          end
        end
        DIVZERO: begin
          state_d  = END;
          result_d = {quot_q, {DATA_W{1'b1}}};
        end
        ON: begin
          rem_d  = rem_next;
          quot_d = quot_next;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d  = END;
            result_d = {r_fix, q_fix};
          end
        end
        END: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      dvsr_q   <= '0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      dvsr_q   <= dvsr_d;
      sign1_q  <= sign1_d;
      sign2_q  <= sign2_d;
      result_q <= result_d;
    end
  end

  assign bus.busy_o   = busy;
  assign bus.ready_o  = ready;
  assign bus.result_o = result_q;
endmodule
